// File: rtl/dds_phase_gen.sv
// dds_phase_gen: DDS phase accumulator, sweep sequencer and ROM address generator
module dds_phase_gen #(
   parameter int ACC_W   = 32,
   parameter int ADDR_W  = 11,
   parameter int DWELL_W = 16
) (
   input  logic               Fg_CLK,
   input  logic               RESETn,
   input  logic               Enable,
   input  logic               Mode,
   input  logic               CfgWr,
   input  logic [ACC_W-1:0]   CfgFreq,
   input  logic [ACC_W-1:0]   CfgStop,
   input  logic [ACC_W-1:0]   CfgStep,
   input  logic [DWELL_W-1:0] CfgDwell,
   input  logic [ACC_W-1:0]   CfgPhase,
   input  logic               SyncClr,
   output logic               CfgAck,
   output logic [ADDR_W-1:0]  Address,
   output logic               AddrValid,
   output logic               DataValid,
   output logic               Wrap,
   output logic               SweepDone,
   output logic [ACC_W-1:0]   CurFreq
);
   typedef enum logic [1:0] {IDLE, FIXED, SWEEP, HOLD} state_t;

   state_t             r_state, w_state_nxt;
   logic [ACC_W-1:0]   r_acc, r_freq, r_phase, r_stop, r_step, w_freq_nxt;
   logic [DWELL_W-1:0] r_dwell, r_dcnt, w_dcnt_nxt, w_dwell_m1;
   logic [ACC_W:0]     w_acc_sum, w_step_sum;
   logic [ADDR_W-1:0]  r_addr, w_addr;
   logic               r_addr_valid, r_data_valid, r_wrap, r_done, r_ack;
   logic               w_done_nxt, w_running, w_dwell_end;

   assign w_running   = (r_state != IDLE) && Enable;
   assign w_acc_sum   = {1'b0, r_acc} + {1'b0, r_freq};
   assign w_step_sum  = {1'b0, r_freq} + {1'b0, r_step};
   assign w_dwell_m1  = (r_dwell == '0) ? '0 : r_dwell - DWELL_W'(1);
   assign w_dwell_end = (r_dcnt == w_dwell_m1);
   assign w_addr      = ADDR_W'((r_acc + r_phase) >> (ACC_W - ADDR_W));

   // Mode and sweep sequencing: config always wins; a sweep that starts at or
   // above its stop word parks in HOLD on its first SWEEP cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_freq_nxt  = r_freq;
      w_dcnt_nxt  = r_dcnt;
      w_done_nxt  = 1'b0;
      if (CfgWr) begin
         w_state_nxt = Mode ? SWEEP : FIXED;
         w_freq_nxt  = CfgFreq;
         w_dcnt_nxt  = '0;
      end else if (r_state == SWEEP) begin
         if (r_freq >= r_stop) begin
            w_state_nxt = HOLD;
            w_done_nxt  = 1'b1;
         end else if (Enable) begin
            if (w_dwell_end) begin
               w_dcnt_nxt = '0;
               if (w_step_sum >= {1'b0, r_stop}) begin
                  w_freq_nxt  = r_stop;
                  w_state_nxt = HOLD;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_freq_nxt = w_step_sum[ACC_W-1:0];
               end
            end else begin
               w_dcnt_nxt = r_dcnt + DWELL_W'(1);
            end
         end
      end
   end

   // State, tuning word and dwell counter registers
   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_state <= IDLE;
         r_freq  <= '0;
         r_dcnt  <= '0;
         r_done  <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_freq  <= w_freq_nxt;
         r_dcnt  <= w_dcnt_nxt;
         r_done  <= w_done_nxt;
         r_ack   <= CfgWr;
      end
   end

   // Latched configuration words; the accumulator is deliberately not touched
   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_phase <= '0;
         r_stop  <= '0;
         r_step  <= '0;
         r_dwell <= '0;
      end else if (CfgWr) begin
         r_phase <= CfgPhase;
         r_stop  <= CfgStop;
         r_step  <= CfgStep;
         r_dwell <= CfgDwell;
      end
   end

   // Phase accumulator with sync clear for multi-channel alignment
   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_acc  <= '0;
         r_wrap <= 1'b0;
      end else begin
         if (SyncClr)        r_acc <= '0;
         else if (w_running) r_acc <= w_acc_sum[ACC_W-1:0];
         r_wrap <= w_running && !SyncClr && w_acc_sum[ACC_W];
      end
   end

   // ROM address and valid pipeline matching the one-cycle ROM latency
   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_addr       <= '0;
         r_addr_valid <= 1'b0;
         r_data_valid <= 1'b0;
      end else begin
         r_addr       <= w_addr;
         r_addr_valid <= w_running;
         r_data_valid <= r_addr_valid;
      end
   end

   assign CfgAck    = r_ack;
   assign Address   = r_addr;
   assign AddrValid = r_addr_valid;
   assign DataValid = r_data_valid;
   assign Wrap      = r_wrap;
   assign SweepDone = r_done;
   assign CurFreq   = r_freq;
endmodule

// File: tb/tb_dds_phase_gen.sv
// tb_dds_phase_gen: directed self-checking bench for dds_phase_gen
module tb_dds_phase_gen;
   logic        Fg_CLK = 1'b0;
   logic        RESETn, Enable, Mode, CfgWr, SyncClr;
   logic [31:0] CfgFreq, CfgStop, CfgStep, CfgPhase;
   logic [15:0] CfgDwell;
   logic        CfgAck, AddrValid, DataValid, Wrap, SweepDone;
   logic [10:0] Address;
   logic [31:0] CurFreq;
   int          n_cmp = 0;
   int          n_err = 0;

   dds_phase_gen dut (
      .Fg_CLK(Fg_CLK), .RESETn(RESETn), .Enable(Enable), .Mode(Mode), .CfgWr(CfgWr),
      .CfgFreq(CfgFreq), .CfgStop(CfgStop), .CfgStep(CfgStep), .CfgDwell(CfgDwell),
      .CfgPhase(CfgPhase), .SyncClr(SyncClr), .CfgAck(CfgAck), .Address(Address),
      .AddrValid(AddrValid), .DataValid(DataValid), .Wrap(Wrap), .SweepDone(SweepDone),
      .CurFreq(CurFreq)
   );

   always #5 Fg_CLK = ~Fg_CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Fg_CLK);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_addr"}, 32'(Address), 0);
      chk({tag, "_freq"}, CurFreq, 0);
      chk({tag, "_av"}, 32'(AddrValid), 0);
      chk({tag, "_dv"}, 32'(DataValid), 0);
      chk({tag, "_ack"}, 32'(CfgAck), 0);
      chk({tag, "_wrap"}, 32'(Wrap), 0);
      chk({tag, "_done"}, 32'(SweepDone), 0);
   endtask

   task automatic cfg(input logic m, input logic sc, input logic [31:0] f, input logic [31:0] st,
                      input logic [31:0] sp, input logic [15:0] dw, input logic [31:0] ph);
      Mode = m; SyncClr = sc; CfgWr = 1'b1;
      CfgFreq = f; CfgStop = st; CfgStep = sp; CfgDwell = dw; CfgPhase = ph;
      step();
      CfgWr = 1'b0; SyncClr = 1'b0;
   endtask

   initial begin
      RESETn = 1'b0; Enable = 1'b0; Mode = 1'b0; CfgWr = 1'b0; SyncClr = 1'b0;
      CfgFreq = '0; CfgStop = '0; CfgStep = '0; CfgDwell = '0; CfgPhase = '0;
      repeat (3) step();
      chk_idle("reset");
      RESETn = 1'b1;
      step();
      chk_idle("idle");

      // fixed frequency, one address step per cycle
      Enable = 1'b1;
      cfg(1'b0, 1'b0, 32'h0020_0000, 0, 0, 0, 0);
      chk("fx_ack", 32'(CfgAck), 1);
      chk("fx_freq", CurFreq, 32'h0020_0000);
      chk("fx_av0", 32'(AddrValid), 0);
      step();
      chk("fx_ack_off", 32'(CfgAck), 0);
      chk("fx_addr1", 32'(Address), 0);
      chk("fx_av1", 32'(AddrValid), 1);
      chk("fx_dv1", 32'(DataValid), 0);
      step();
      chk("fx_addr2", 32'(Address), 1);
      chk("fx_dv2", 32'(DataValid), 1);
      for (int k = 3; k <= 2049; k++) begin
         step();
         chk("fx_addr", 32'(Address), 32'((k - 1) % 2048));
         chk("fx_wrap", 32'(Wrap), (k == 2048) ? 1 : 0);
      end

      // freeze with Enable low, then resume
      Enable = 1'b0;
      step();
      chk("frz_av", 32'(AddrValid), 0);
      chk("frz_dv_lag", 32'(DataValid), 1);
      for (int k = 2; k <= 10; k++) begin
         step();
         chk("frz_addr", 32'(Address), 1);
         chk("frz_av_k", 32'(AddrValid), 0);
      end
      chk("frz_dv", 32'(DataValid), 0);
      Enable = 1'b1;
      step();
      chk("res_av", 32'(AddrValid), 1);
      chk("res_addr1", 32'(Address), 1);
      step();
      chk("res_addr2", 32'(Address), 2);

      // half-rate tuning word with quarter-turn phase offset
      cfg(1'b0, 1'b1, 32'h8000_0000, 0, 0, 0, 32'h4000_0000);
      chk("hr_ack", 32'(CfgAck), 1);
      chk("hr_wrap0", 32'(Wrap), 0);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("hr_addr", 32'(Address), (k % 2 == 1) ? 512 : 1536);
         chk("hr_wrap", 32'(Wrap), (k % 2 == 0) ? 1 : 0);
      end

      // linear sweep, dwell 4
      cfg(1'b1, 1'b1, 32'h0020_0000, 32'h0080_0000, 32'h0020_0000, 16'd4, 0);
      chk("sw_freq0", CurFreq, 32'h0020_0000);
      for (int i = 1; i <= 20; i++) begin
         step();
         chk("sw_freq", CurFreq, (i >= 12) ? 32'h0080_0000 : 32'h0020_0000 * 32'(i / 4 + 1));
         chk("sw_done", 32'(SweepDone), (i == 12) ? 1 : 0);
      end

      // sync clear with reconfiguration in the middle of a sweep
      cfg(1'b1, 1'b0, 32'h0020_0000, 32'h0080_0000, 32'h0020_0000, 16'd4, 0);
      repeat (6) step();
      cfg(1'b1, 1'b1, 32'h0020_0000, 32'h0080_0000, 32'h0020_0000, 16'd2, 32'h1000_0000);
      chk("sc_freq0", CurFreq, 32'h0020_0000);
      step();
      chk("sc_addr1", 32'(Address), 128);
      chk("sc_freq1", CurFreq, 32'h0020_0000);
      step();
      chk("sc_addr2", 32'(Address), 129);
      chk("sc_freq2", CurFreq, 32'h0040_0000);
      step();
      chk("sc_addr3", 32'(Address), 130);
      step();
      chk("sc_addr4", 32'(Address), 132);

      // sweep configured with stop below start parks immediately
      cfg(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0080, 32'h0000_0010, 16'd0, 0);
      chk("dg_ack", 32'(CfgAck), 1);
      chk("dg_done0", 32'(SweepDone), 0);
      step();
      chk("dg_done1", 32'(SweepDone), 1);
      chk("dg_freq", CurFreq, 32'h0000_0100);
      step();
      chk("dg_done2", 32'(SweepDone), 0);
      chk("dg_hold", CurFreq, 32'h0000_0100);

      // asynchronous reset in the middle of a sweep
      cfg(1'b1, 1'b1, 32'h0020_0000, 32'h0080_0000, 32'h0020_0000, 16'd4, 32'h4000_0000);
      repeat (5) step();
      chk("ar_pre_addr", 32'(Address), 516);
      #2;
      RESETn = 1'b0;
      #1;
      chk_idle("ar_low");
      #3;
      RESETn = 1'b1;
      repeat (5) step();
      chk_idle("ar_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
